// File: rtl/lane_rr_sched.sv
// Round-robin scheduler granting one of N lanes for up to BURST cycles, with a writable enable mask.
// Optional: define LANE_RR_SCHED_PRIO0_EN to give lane 0 strict priority in arbitration.
module lane_rr_sched #(
   parameter int N     = 32,
   parameter int BURST = 4,
   localparam int IW   = (N > 1) ? $clog2(N) : 1
) (
   input  logic          c,
   input  logic          r,
   input  logic [N-1:0]  req,
   input  logic          mask_we,
   input  logic [N-1:0]  mask_wdata,
   output logic [N-1:0]  mask,
   output logic [N-1:0]  gnt,
   output logic          gnt_valid,
   output logic [IW-1:0] gnt_idx,
   output logic          done
);

   localparam int            CW = $clog2(BURST + 1);
   localparam logic [IW:0]   NW = (IW+1)'(N);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [N-1:0]    gnt_q, gnt_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            vld_q, vld_d;
   logic            done_q, done_d;
   logic [N-1:0]    mask_q, mask_d;

   logic [N-1:0]    elig;
   logic            sel_found;
   logic [IW-1:0]   sel_idx;
   logic [IW:0]     cand;
   logic [IW:0]     nxt;
   logic            end_cond;

   // Wrapping search upward from ptr; the first eligible lane wins.
   always_comb begin
      elig      = req & mask_q;
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int i = 0; i < N; i++) begin
         cand = {1'b0, ptr_q} + (IW+1)'(i);
         if (cand >= NW)
            cand = cand - NW;
         if (!sel_found && elig[cand[IW-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = cand[IW-1:0];
         end
      end
`ifdef LANE_RR_SCHED_PRIO0_EN
      if (elig[0]) begin
         sel_found = 1'b1;
         sel_idx   = '0;
      end
`endif
   end

   always_comb begin
      nxt = {1'b0, idx_q} + (IW+1)'(1);
      if (nxt >= NW)
         nxt = '0;
      end_cond = (cnt_q == CW'(BURST)) || !req[idx_q] || !mask_q[idx_q];
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      vld_d   = vld_q;
      done_d  = 1'b0;
      mask_d  = mask_we ? mask_wdata : mask_q;
      case (state_q)
         IDLE: begin
            gnt_d = '0;
            vld_d = 1'b0;
            if (sel_found) begin
               gnt_d[sel_idx] = 1'b1;
               idx_d          = sel_idx;
               vld_d          = 1'b1;
               cnt_d          = CW'(1);
               state_d        = GRANT;
            end
         end
         GRANT: begin
            if (end_cond) begin
               // Simultaneous end conditions collapse into this single exit.
               gnt_d   = '0;
               vld_d   = 1'b0;
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
`ifdef LANE_RR_SCHED_PRIO0_EN
               if (idx_q != '0)
                  ptr_d = nxt[IW-1:0];
`else
               ptr_d = nxt[IW-1:0];
`endif
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge c) begin
      if (!r) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         idx_q   <= '0;
         vld_q   <= 1'b0;
         done_q  <= 1'b0;
         mask_q  <= '1;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         vld_q   <= vld_d;
         done_q  <= done_d;
         mask_q  <= mask_d;
      end
   end

   assign mask      = mask_q;
   assign gnt       = gnt_q;
   assign gnt_valid = vld_q;
   assign gnt_idx   = idx_q;
   assign done      = done_q;

endmodule

// File: tb/tb_lane_rr_sched.sv
// Directed bench for lane_rr_sched (N=32, BURST=4) with hand-computed grant sequences.
module tb_lane_rr_sched;

   logic        c;
   logic        r;
   logic [31:0] req;
   logic        mask_we;
   logic [31:0] mask_wdata;
   logic [31:0] mask;
   logic [31:0] gnt;
   logic        gnt_valid;
   logic [4:0]  gnt_idx;
   logic        done;

   int tests  = 0;
   int failed = 0;

   lane_rr_sched #(.N(32), .BURST(4)) dut (
      .c(c), .r(r), .req(req), .mask_we(mask_we), .mask_wdata(mask_wdata),
      .mask(mask), .gnt(gnt), .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .done(done)
   );

   initial c = 1'b0;
   always #5 c = ~c;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge c);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] eg, input int ei, input logic ed);
      logic [4:0] eidx;
      eidx = ei[4:0];
      tests++;
      assert (gnt === eg) else begin
         failed++;
         $error("FAIL %s gnt got %h expected %h", tag, gnt, eg);
      end
      tests++;
      assert (gnt_valid === (eg != 32'h0)) else begin
         failed++;
         $error("FAIL %s gnt_valid got %b expected %b", tag, gnt_valid, (eg != 32'h0));
      end
      if (eg != 32'h0) begin
         tests++;
         assert (gnt_idx === eidx) else begin
            failed++;
            $error("FAIL %s gnt_idx got %0d expected %0d", tag, gnt_idx, eidx);
         end
      end
      tests++;
      assert (done === ed) else begin
         failed++;
         $error("FAIL %s done got %b expected %b", tag, done, ed);
      end
   endtask

   task automatic chk_idx0(input string tag);
      tests++;
      assert (gnt_idx === 5'd0) else begin
         failed++;
         $error("FAIL %s gnt_idx got %0d expected 0", tag, gnt_idx);
      end
   endtask

   task automatic chk_mask(input string tag, input logic [31:0] em);
      tests++;
      assert (mask === em) else begin
         failed++;
         $error("FAIL %s mask got %h expected %h", tag, mask, em);
      end
   endtask

   task automatic hold(input string tag, input int lane, input int n);
      for (int k = 0; k < n; k++) begin
         step();
         chk(tag, 32'h1 << lane, lane, 1'b0);
      end
   endtask

   task automatic burst(input string tag, input int lane);
      step();
      chk(tag, 32'h1 << lane, lane, 1'b0);
      hold(tag, lane, 3);
      step();
      chk({tag, "_gap"}, 32'h0, 0, 1'b1);
   endtask

   initial begin
      r          = 1'b0;
      req        = 32'hFFFF_FFFF;
      mask_we    = 1'b0;
      mask_wdata = 32'h0;
      repeat (3) step();
      chk("rst", 32'h0, 0, 1'b0);
      chk_idx0("rst");
      chk_mask("rst_mask", 32'hFFFF_FFFF);

      r = 1'b1;
      step();
      chk("first", 32'h1, 0, 1'b0);

`ifdef LANE_RR_SCHED_PRIO0_EN
      req = 32'h0000_0010;
      step();
      chk("p_drop0", 32'h0, 0, 1'b1);
      step();
      chk("p_l4", 32'h10, 4, 1'b0);
      req = 32'h0000_0031;
      hold("p_l4", 4, 3);
      step();
      chk("p_l4_gap", 32'h0, 0, 1'b1);
      burst("p_l0a", 0);
      burst("p_l0b", 0);
`else
      // Rotation over lanes 0, 2, 8, 0 with 4-cycle bursts.
      req = 32'h0000_0105;
      hold("rot0", 0, 3);
      step();
      chk("rot0_gap", 32'h0, 0, 1'b1);
      burst("rot2", 2);
      burst("rot8", 8);
      burst("rot0b", 0);

      // Early release of lane 3 after two granted cycles; ptr becomes 4.
      req = 32'h0000_0008;
      step();
      chk("early_l3", 32'h8, 3, 1'b0);
      step();
      chk("early_l3_hold", 32'h8, 3, 1'b0);
      req = 32'h0;
      step();
      chk("early_done", 32'h0, 0, 1'b1);
      req = 32'h0000_0011;
      step();
      chk("ptr4", 32'h10, 4, 1'b0);
      req = 32'h0;
      step();
      chk("ptr4_done", 32'h0, 0, 1'b1);
      step();
      chk("idle", 32'h0, 0, 1'b0);

      // Mask out the active lane 1.
      req = 32'h0000_0002;
      step();
      chk("mask_l1", 32'h2, 1, 1'b0);
      step();
      chk("mask_l1_hold", 32'h2, 1, 1'b0);
      mask_we    = 1'b1;
      mask_wdata = 32'hFFFF_FFFD;
      step();
      chk("mask_l1_hold2", 32'h2, 1, 1'b0);
      chk_mask("mask_wr", 32'hFFFF_FFFD);
      mask_we = 1'b0;
      step();
      chk("mask_end", 32'h0, 0, 1'b1);
      step();
      chk("mask_block", 32'h0, 0, 1'b0);
      step();
      chk("mask_block2", 32'h0, 0, 1'b0);

      // Mask of zero ignores all requests.
      mask_we    = 1'b1;
      mask_wdata = 32'h0;
      step();
      chk("mask0", 32'h0, 0, 1'b0);
      chk_mask("mask0_val", 32'h0);
      mask_we = 1'b0;
      req     = 32'hFFFF_FFFF;
      step();
      chk("mask0_all", 32'h0, 0, 1'b0);
      step();
      chk("mask0_all2", 32'h0, 0, 1'b0);
      mask_we    = 1'b1;
      mask_wdata = 32'hFFFF_FFFF;
      req        = 32'h0;
      step();
      chk("mask_restore", 32'h0, 0, 1'b0);
      mask_we = 1'b0;
      chk_mask("mask_restore_val", 32'hFFFF_FFFF);

      // Move ptr to 31, then wrap to lane 0 with simultaneous end conditions.
      req = 32'h4000_0000;
      step();
      chk("wrap_l30", 32'h4000_0000, 30, 1'b0);
      req = 32'h0;
      step();
      chk("wrap_l30_done", 32'h0, 0, 1'b1);
      req = 32'h8000_0001;
      step();
      chk("wrap_l31", 32'h8000_0000, 31, 1'b0);
      hold("wrap_l31", 31, 3);
      req = 32'h0000_0001;
      step();
      chk("wrap_done", 32'h0, 0, 1'b1);
      step();
      chk("wrap_l0", 32'h1, 0, 1'b0);

      // Reset in the middle of a lane-31 grant (ptr=1 before reset).
      step();
      chk("pre_rst_l0", 32'h1, 0, 1'b0);
      req = 32'h8000_0000;
      step();
      chk("pre_rst_done", 32'h0, 0, 1'b1);
      step();
      chk("pre_rst_l31", 32'h8000_0000, 31, 1'b0);
      step();
      chk("pre_rst_l31_hold", 32'h8000_0000, 31, 1'b0);
      r   = 1'b0;
      req = 32'h8000_0001;
      step();
      chk("rst_mid", 32'h0, 0, 1'b0);
      chk_idx0("rst_mid");
      r = 1'b1;
      step();
      chk("restart_l0", 32'h1, 0, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/lane_rr_sched.md
Name: lane_rr_sched

Overview:
- Round-robin scheduler that shares one lane-update resource between N requesters, e.g. a generated bank of 1-bit sequential cells.
- Each lane raises a request. The scheduler grants exactly one lane at a time for a bounded burst, then rotates.
- A software-writable enable mask excludes lanes from arbitration.
- Sits between lane request logic and the shared bank's enable/select inputs.

Parameters:
- N, 32, number of requesting lanes (>=1).
- BURST, 4, maximum consecutive granted cycles per grant (>=1).
- IW, $clog2(N) (min 1), width of the grant index (derived; not overridden).

Ports:
- c  input  1  clock; all logic on posedge c.
- r  input  1  reset, synchronous, active-low (r=0 resets on the next posedge c).
- req  input  N  per-lane request, level-sensitive.
- mask_we  input  1  mask write strobe.
- mask_wdata  input  N  new mask value.
- mask  output  N  current enable mask; 1 = lane eligible.
- gnt  output  N  one-hot grant, registered.
- gnt_valid  output  1  high when any gnt bit is set.
- gnt_idx  output  IW  binary index of the granted lane; valid only when gnt_valid=1.
- done  output  1  one-cycle pulse marking the end of a grant.

Behaviour:
- Reset (r=0 at posedge c):
  - gnt=0, gnt_valid=0, gnt_idx=0, done=0.
  - mask all ones.
  - Round-robin pointer ptr=0, burst counter=0, state IDLE.
  - Reset mid-grant drops gnt on that same edge; no done pulse is produced.
- Eligibility: elig = req & mask, both sampled at the current edge.
- State machine: IDLE and GRANT.
- IDLE:
  - If elig != 0, select the first set bit of elig searching upward from ptr with wrap (ptr, ptr+1, ..., N-1, 0, ..., ptr-1).
  - Register gnt, gnt_idx and gnt_valid=1, set the counter to 1, and go to GRANT.
  - Latency: req rising at edge k gives gnt at edge k+1.
  - If elig == 0, stay in IDLE with outputs at zero.
- GRANT, end condition (any of these):
  - counter == BURST;
  - req[gnt_idx] == 0;
  - mask[gnt_idx] == 0.
- GRANT, end actions:
  - Clear gnt and gnt_valid, pulse done=1 for exactly one cycle.
  - Set ptr = (gnt_idx+1) mod N, go to IDLE.
  - If several end conditions hold in the same cycle, produce a single done pulse.
- GRANT, otherwise: increment the counter and hold gnt.
- Back-to-back grants are separated by exactly one idle cycle (the IDLE evaluation cycle). done is high in that cycle.
- A lane that keeps requesting gets at most BURST consecutive cycles. After its grant, every other eligible lane is served before it is served again.
- Mask write:
  - mask <= mask_wdata on the edge where mask_we=1.
  - The new value is visible at the next edge's eligibility evaluation.
  - Clearing the active lane's bit ends its grant one cycle later, with done.
  - Writing mask=0 blocks all grants; req is ignored.
- N=1: ptr stays 0; the single lane is re-granted after each one-cycle gap.
- Wrap-around: ptr=N-1 followed by a grant to lane N-1 sets ptr=0.
- Invariant: gnt is one-hot or zero at all times.

Optional Feature:
- Macro: LANE_RR_SCHED_PRIO0_EN.
- When defined:
  - Lane 0 is high priority. In IDLE, if elig[0]=1 it wins regardless of ptr.
  - A lane-0 grant leaves ptr unchanged.
  - A lane-0 grant is still limited by BURST and is followed by the one-cycle gap.
- When undefined: pure round-robin as above; lane 0 has no special treatment.

Test Plan:
- Reset: hold r=0 for 3 cycles with req all ones -> gnt=0, gnt_valid=0, done=0, mask=32'hFFFF_FFFF. Release r -> first gnt=32'h1, gnt_idx=0, one cycle after release.
- Rotation: req=32'h0000_0105 held, BURST=4 -> grants to lanes 0, 2, 8, 0, ..., each 4 cycles long, 1-cycle gaps, done pulses in each gap.
- Early release: lane 3 granted, req[3] dropped after 2 granted cycles -> gnt clears on the following edge, done=1 for one cycle, ptr=4.
- Mask: mask_we with 32'hFFFF_FFFD while lane 1 is granted -> lane 1 grant ends next cycle with done; lane 1 is not granted again while its req stays high.
- Wrap and simultaneity: ptr=31, req=32'h8000_0001 -> lane 31 granted first, then lane 0. Set req[31]=0 on its 4th granted cycle -> exactly one done pulse.
- Reset mid-grant with r=0 -> gnt=0 and done=0 on that edge; after r=1, arbitration restarts from lane 0. With LANE_RR_SCHED_PRIO0_EN defined, req=32'h0000_0011 -> lane 0 wins every arbitration that follows a lane-0 or a lane-4 grant.
